// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control blocks.
// Contents:
//   hz_state_t                    - hazard controller FSM states
//   FWD_REG, FWD_EXMEM, FWD_MEMWB - EX operand forwarding select codes
//   REG_W                         - register specifier width
package cpu_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-stage information consumed by the hazard controller,
// together with the stall, flush and forwarding controls it returns.
// Modports:
//   master - pipeline side: drives the ID/EX/MEM/WB fields and receives the
//            IF_IDstall, jumpClear and fwdA_sel/fwdB_sel controls.
//   slave  - hazard controller side (the reverse directions).
interface hazard_ctrl_if;
    import cpu_pkg::*;

    logic [REG_W-1:0] id_Areg;
    logic [REG_W-1:0] id_Breg;
    logic             id_useA;
    logic             id_useB;
    logic [REG_W-1:0] ex_targetReg;
    logic             ex_regWrite;
    logic             ex_memRead;
    logic             ex_jumpEnable;
    logic [REG_W-1:0] ex_Areg;
    logic [REG_W-1:0] ex_Breg;
    logic [REG_W-1:0] mem_targetReg;
    logic             mem_regWrite;
    logic [REG_W-1:0] wb_targetReg;
    logic             wb_regWrite;
    logic             IF_IDstall;
    logic             jumpClear;
    logic [1:0]       fwdA_sel;
    logic [1:0]       fwdB_sel;

    modport master (
        output id_Areg, id_Breg, id_useA, id_useB,
        output ex_targetReg, ex_regWrite, ex_memRead, ex_jumpEnable,
        output ex_Areg, ex_Breg,
        output mem_targetReg, mem_regWrite, wb_targetReg, wb_regWrite,
        input  IF_IDstall, jumpClear, fwdA_sel, fwdB_sel
    );

    modport slave (
        input  id_Areg, id_Breg, id_useA, id_useB,
        input  ex_targetReg, ex_regWrite, ex_memRead, ex_jumpEnable,
        input  ex_Areg, ex_Breg,
        input  mem_targetReg, mem_regWrite, wb_targetReg, wb_regWrite,
        output IF_IDstall, jumpClear, fwdA_sel, fwdB_sel
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one EX operand (purely combinational).
// Ports:
//   src        in  source register of the EX instruction for this operand
//   mem_target in  destination in EX/MEM;  mem_wr in  EX/MEM writes
//   wb_target  in  destination in MEM/WB;  wb_wr  in  MEM/WB writes
//   sel        out FWD_REG / FWD_EXMEM / FWD_MEMWB
// Parameter R0_ZERO: register 0 is hard-wired zero and is never forwarded.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_target,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] wb_target,
    input  logic             wb_wr,
    output logic [1:0]       sel
);

    logic src_is_r0;

    assign src_is_r0 = R0_ZERO && (src == '0);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        sel = FWD_REG;
        if (!src_is_r0) begin
            if (mem_wr && (mem_target == src)) begin
                sel = FWD_EXMEM;
            end else if (wb_wr && (wb_target == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the ID/EX register.
//   - Load-use hazard between ID and EX: raises IF_IDstall for
//     LOAD_STALL_CYCLES cycles (IF/ID and PC hold, ID/EX loads a bubble).
//   - Jump resolved in EX: raises jumpClear for JUMP_FLUSH_CYCLES cycles
//     (IF/ID and ID/EX load bubbles). Jumps always beat load-use stalls.
//   - EX operand forwarding selects from EX/MEM and MEM/WB.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   bus   hazard_ctrl_if.slave - stage info in, IF_IDstall / jumpClear /
//         fwdA_sel / fwdB_sel out (all outputs are combinational)
//   stall_cnt, flush_cnt out [15:0] - only when HAZARD_PERF_CNT_EN is
//         defined: saturating counts of stall and flush cycles.
// Optional feature macro: HAZARD_PERF_CNT_EN
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int JUMP_FLUSH_CYCLES = 1,
    parameter bit R0_ZERO           = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    hazard_ctrl_if.slave bus
);

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(JUMP_FLUSH_CYCLES - 1);
    localparam bit MULTI_STALL = (LOAD_STALL_CYCLES > 1);
    localparam bit MULTI_FLUSH = (JUMP_FLUSH_CYCLES > 1);

    hz_state_t  state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       stall, jclr;
    logic       match_a, match_b, lu;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // A source register matches when EX writes it; r0 optionally never does.
    assign match_a = bus.ex_regWrite && (bus.id_Areg == bus.ex_targetReg)
                     && !(R0_ZERO && (bus.id_Areg == '0));
    assign match_b = bus.ex_regWrite && (bus.id_Breg == bus.ex_targetReg)
                     && !(R0_ZERO && (bus.id_Breg == '0));
    assign lu      = bus.ex_memRead
                     && ((bus.id_useA && match_a) || (bus.id_useB && match_b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        jclr      = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.ex_jumpEnable) begin
                    jclr = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = FLUSH_RELOAD;
                    end
                end else if (lu) begin
                    stall = 1'b1;
                    if (MULTI_STALL) begin
                        state_nxt = STALL;
                        cnt_nxt   = STALL_RELOAD;
                    end
                end
            end
            STALL: begin
                if (bus.ex_jumpEnable) begin
                    // The jump squashes the stalled instruction anyway.
                    jclr = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = FLUSH_RELOAD;
                    end else begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end else begin
                    stall = 1'b1;
                    if (cnt == 3'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
            end
            FLUSH: begin
                jclr = 1'b1;
                if (bus.ex_jumpEnable) begin
                    cnt_nxt = FLUSH_RELOAD;
                end else if (cnt == 3'd1) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
        // During reset the unreset ID/EX register is filled with bubbles.
        if (!rst_n) begin
            stall = 1'b0;
            jclr  = 1'b1;
        end
    end

    fwd_unit #(.R0_ZERO(R0_ZERO)) u_fwd_a (
        .src        (bus.ex_Areg),
        .mem_target (bus.mem_targetReg),
        .mem_wr     (bus.mem_regWrite),
        .wb_target  (bus.wb_targetReg),
        .wb_wr      (bus.wb_regWrite),
        .sel        (fwd_a_raw)
    );

    fwd_unit #(.R0_ZERO(R0_ZERO)) u_fwd_b (
        .src        (bus.ex_Breg),
        .mem_target (bus.mem_targetReg),
        .mem_wr     (bus.mem_regWrite),
        .wb_target  (bus.wb_targetReg),
        .wb_wr      (bus.wb_regWrite),
        .sel        (fwd_b_raw)
    );

    assign bus.IF_IDstall = stall;
    assign bus.jumpClear  = jclr;
    assign bus.fwdA_sel   = rst_n ? fwd_a_raw : FWD_REG;
    assign bus.fwdB_sel   = rst_n ? fwd_b_raw : FWD_REG;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (jclr && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share one stimulus:
//   u1: LOAD_STALL_CYCLES=1, JUMP_FLUSH_CYCLES=1, R0_ZERO=1
//   u3: LOAD_STALL_CYCLES=3, JUMP_FLUSH_CYCLES=2, R0_ZERO=1
module tb_hazard_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] id_Areg, id_Breg, ex_targetReg, ex_Areg, ex_Breg;
    logic [2:0] mem_targetReg, wb_targetReg;
    logic       id_useA, id_useB, ex_regWrite, ex_memRead, ex_jumpEnable;
    logic       mem_regWrite, wb_regWrite;

    always #5 clk = ~clk;

    hazard_ctrl_if h1 ();
    hazard_ctrl_if h3 ();

    assign h1.id_Areg = id_Areg;             assign h3.id_Areg = id_Areg;
    assign h1.id_Breg = id_Breg;             assign h3.id_Breg = id_Breg;
    assign h1.id_useA = id_useA;             assign h3.id_useA = id_useA;
    assign h1.id_useB = id_useB;             assign h3.id_useB = id_useB;
    assign h1.ex_targetReg = ex_targetReg;   assign h3.ex_targetReg = ex_targetReg;
    assign h1.ex_regWrite = ex_regWrite;     assign h3.ex_regWrite = ex_regWrite;
    assign h1.ex_memRead = ex_memRead;       assign h3.ex_memRead = ex_memRead;
    assign h1.ex_jumpEnable = ex_jumpEnable; assign h3.ex_jumpEnable = ex_jumpEnable;
    assign h1.ex_Areg = ex_Areg;             assign h3.ex_Areg = ex_Areg;
    assign h1.ex_Breg = ex_Breg;             assign h3.ex_Breg = ex_Breg;
    assign h1.mem_targetReg = mem_targetReg; assign h3.mem_targetReg = mem_targetReg;
    assign h1.mem_regWrite = mem_regWrite;   assign h3.mem_regWrite = mem_regWrite;
    assign h1.wb_targetReg = wb_targetReg;   assign h3.wb_targetReg = wb_targetReg;
    assign h1.wb_regWrite = wb_regWrite;     assign h3.wb_regWrite = wb_regWrite;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] s1, f1, s3, f3;
`endif

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .JUMP_FLUSH_CYCLES(1), .R0_ZERO(1'b1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt (s1),
        .flush_cnt (f1),
`endif
        .bus   (h1)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .JUMP_FLUSH_CYCLES(2), .R0_ZERO(1'b1)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt (s3),
        .flush_cnt (f3),
`endif
        .bus   (h3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_Areg = 0; id_Breg = 0; id_useA = 0; id_useB = 0;
        ex_targetReg = 0; ex_regWrite = 0; ex_memRead = 0; ex_jumpEnable = 0;
        ex_Areg = 0; ex_Breg = 0;
        mem_targetReg = 0; mem_regWrite = 0; wb_targetReg = 0; wb_regWrite = 0;
    endtask

    initial begin
        // Reset: forwarding inputs match, yet selects must read 00.
        clr();
        mem_targetReg = 5; mem_regWrite = 1; ex_Areg = 5; ex_Breg = 5;
        tick();
        tick();
        chk("rst_stall", 16'(h1.IF_IDstall), 16'd0);
        chk("rst_jclr", 16'(h1.jumpClear), 16'd1);
        chk("rst_fwdA", 16'(h1.fwdA_sel), 16'd0);
        chk("rst_fwdB", 16'(h1.fwdB_sel), 16'd0);
        chk("rst_state", 16'(u3.state), 16'(RUN));
        chk("rst_cnt", 16'(u3.cnt), 16'd0);
        rst_n = 1'b1;
        clr();
        #1;
        chk("idle_stall", 16'(h1.IF_IDstall), 16'd0);
        chk("idle_jclr", 16'(h1.jumpClear), 16'd0);

        // Load r3 in EX, ID reads r3 via A.
        id_Areg = 3; id_useA = 1; ex_targetReg = 3; ex_regWrite = 1; ex_memRead = 1;
        #1;
        chk("lu1_stall", 16'(h1.IF_IDstall), 16'd1);
        chk("lu1_jclr", 16'(h1.jumpClear), 16'd0);
        chk("lu3_stall0", 16'(h3.IF_IDstall), 16'd1);
        tick();
        ex_memRead = 0; ex_regWrite = 0;
        #1;
        chk("lu1_after", 16'(h1.IF_IDstall), 16'd0);
        chk("lu3_stall1", 16'(h3.IF_IDstall), 16'd1);
        chk("lu3_state1", 16'(u3.state), 16'(STALL));
        chk("lu3_cnt1", 16'(u3.cnt), 16'd2);
        tick();
        chk("lu3_stall2", 16'(h3.IF_IDstall), 16'd1);
        chk("lu3_cnt2", 16'(u3.cnt), 16'd1);
        tick();
        chk("lu3_done", 16'(h3.IF_IDstall), 16'd0);
        chk("lu3_state3", 16'(u3.state), 16'(RUN));

        // Jump arriving while u3 is in STALL.
        ex_memRead = 1; ex_regWrite = 1;
        #1;
        chk("js_stall", 16'(h3.IF_IDstall), 16'd1);
        tick();
        ex_memRead = 0; ex_regWrite = 0; ex_jumpEnable = 1;
        #1;
        chk("js_jclr", 16'(h3.jumpClear), 16'd1);
        chk("js_nostall", 16'(h3.IF_IDstall), 16'd0);
        chk("js_u1_jclr", 16'(h1.jumpClear), 16'd1);
        tick();
        ex_jumpEnable = 0;
        #1;
        chk("js_flush_st", 16'(u3.state), 16'(FLUSH));
        chk("js_jclr2", 16'(h3.jumpClear), 16'd1);
        chk("js_nostall2", 16'(h3.IF_IDstall), 16'd0);
        chk("js_u1_clear", 16'(h1.jumpClear), 16'd0);
        tick();
        chk("js_end", 16'(h3.jumpClear), 16'd0);
        chk("js_run", 16'(u3.state), 16'(RUN));

        // Jump beats load-use in RUN; a second jump in FLUSH reloads.
        ex_memRead = 1; ex_regWrite = 1; ex_jumpEnable = 1;
        #1;
        chk("pri_jclr", 16'(h1.jumpClear), 16'd1);
        chk("pri_stall", 16'(h1.IF_IDstall), 16'd0);
        tick();
        ex_memRead = 0; ex_regWrite = 0;
        tick();
        chk("reload_st", 16'(u3.state), 16'(FLUSH));
        ex_jumpEnable = 0;
        #1;
        chk("reload_jclr", 16'(h3.jumpClear), 16'd1);
        tick();
        chk("reload_end", 16'(h3.jumpClear), 16'd0);

        // Forwarding selects.
        clr();
        mem_targetReg = 5; mem_regWrite = 1; wb_targetReg = 5; wb_regWrite = 1;
        ex_Areg = 5; ex_Breg = 2;
        #1;
        chk("fwdA_exmem", 16'(h1.fwdA_sel), 16'd1);
        chk("fwdB_none", 16'(h1.fwdB_sel), 16'd0);
        mem_regWrite = 0;
        #1;
        chk("fwdA_memwb", 16'(h1.fwdA_sel), 16'd2);
        ex_Breg = 5;
        #1;
        chk("fwdB_memwb", 16'(h3.fwdB_sel), 16'd2);
        mem_targetReg = 0; mem_regWrite = 1; wb_targetReg = 0; ex_Breg = 0;
        #1;
        chk("fwdB_r0", 16'(h1.fwdB_sel), 16'd0);

        // Load to r0 never stalls; B path does.
        clr();
        ex_targetReg = 0; ex_regWrite = 1; ex_memRead = 1; id_Areg = 0; id_useA = 1;
        #1;
        chk("r0_nostall", 16'(h1.IF_IDstall), 16'd0);
        ex_targetReg = 3; id_Breg = 3; id_useB = 1;
        #1;
        chk("luB_stall", 16'(h1.IF_IDstall), 16'd1);
        id_useB = 0;
        #1;
        chk("luB_unused", 16'(h1.IF_IDstall), 16'd0);
        clr();

        // Reset mid-FLUSH.
        ex_jumpEnable = 1;
        tick();
        chk("mid_flush", 16'(u3.state), 16'(FLUSH));
        ex_jumpEnable = 0;
        rst_n = 1'b0;
        #1;
        chk("abort_state", 16'(u3.state), 16'(RUN));
        chk("abort_cnt", 16'(u3.cnt), 16'd0);
        chk("abort_jclr", 16'(h3.jumpClear), 16'd1);
        chk("abort_stall", 16'(h3.IF_IDstall), 16'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_jclr", 16'(h3.jumpClear), 16'd0);
        chk("rel_state", 16'(u3.state), 16'(RUN));

`ifdef HAZARD_PERF_CNT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clr();
        #1;
        chk("perf_clr", s1, 16'd0);
        id_Areg = 3; id_useA = 1; ex_targetReg = 3; ex_regWrite = 1; ex_memRead = 1;
        for (int i = 0; i < 4; i++) tick();
        clr();
        ex_jumpEnable = 1;
        for (int i = 0; i < 2; i++) tick();
        clr();
        #1;
        chk("perf_stall", s1, 16'd4);
        chk("perf_flush", f1, 16'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
